sponge_squeeze_stream: RTL and testbench

//  Parametrised squeeze engine for the sponge datapath. Takes a full sponge state (rate||capacity) and a

---
 rtl/sponge_squeeze_stream_pkg.sv | 45 ++++
 rtl/sponge_squeeze_stream_if.sv | 46 ++++
 rtl/sponge_squeeze_stream_fmt.sv | 45 ++++
 rtl/sponge_squeeze_stream.sv | 139 +++++++++++++
 tb/tb_sponge_squeeze_stream.sv | 319 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sponge_squeeze_stream_pkg.sv
// ============================================================================
// Module      : sponge_pkg
// Description : Shared types and helpers for the sponge squeeze datapath:
//               squeeze FSM state encoding, MSB-aligned rate mask generator
//               and block-length helper.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sponge_pkg;

    // Widest rate the mask helper can produce; callers size-cast to RWIDTH.
    localparam int unsigned MAX_RWIDTH = 512;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_EMIT      = 3'd1,
        S_PERM_REQ  = 3'd2,
        S_PERM_WAIT = 3'd3,
        S_FINISH    = 3'd4
    } squeeze_state_t;

    // Mask of `width` bits (LSB-aligned in the return value) whose top `len`
    // bits are set. len is at most width.
    function automatic logic [MAX_RWIDTH-1:0] rate_mask(input int unsigned len,
                                                       input int unsigned width);
        logic [MAX_RWIDTH-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < MAX_RWIDTH; i++) begin
            if ((i < width) && ((i + len) >= width)) begin
                m[i] = 1'b1;
            end
        end
        return m;
    endfunction

    // Bits carried by the next block: the remaining length, capped at the rate.
    function automatic int unsigned min_len(input int unsigned remain,
                                            input int unsigned width);
        return (remain < width) ? remain : width;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sponge_squeeze_stream_if.sv
// ============================================================================
// Module      : sponge_squeeze_stream_if
// Description : Output block stream (valid/ready) and permutation
//               start/done handshake of the squeeze engine.
//               master : squeeze engine side
//               slave  : consumer / permutation side
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface sponge_squeeze_stream_if #(
    parameter int unsigned RWIDTH      = 32,
    parameter int unsigned CWIDTH      = 320,
    parameter int unsigned ROUND_COUNT = 10
);
    localparam int unsigned SWIDTH = RWIDTH + CWIDTH;
    localparam int unsigned BITSW  = $clog2(RWIDTH) + 1;

    logic [RWIDTH-1:0]      out_data;
    logic [BITSW-1:0]       out_bits;
    logic                   out_valid;
    logic                   out_ready;
    logic                   out_last;
    logic                   perm_start;
    logic [SWIDTH-1:0]      perm_state_o;
    logic [ROUND_COUNT-1:0] perm_rounds;
    logic                   perm_done;
    logic [SWIDTH-1:0]      perm_state_i;

    modport master (
        output out_data, out_bits, out_valid, out_last,
        input  out_ready,
        output perm_start, perm_state_o, perm_rounds,
        input  perm_done, perm_state_i
    );

    modport slave (
        input  out_data, out_bits, out_valid, out_last,
        output out_ready,
        input  perm_start, perm_state_o, perm_rounds,
        output perm_done, perm_state_i
    );

endinterface

`default_nettype wire

// File: rtl/sponge_squeeze_stream_fmt.sv
// ============================================================================
// Module      : squeeze_block_fmt
// Description : Combinational block formatter. Extracts the rate from the
//               sponge state, keeps the top min(remain,RWIDTH) bits and
//               reports the valid bit count and the last-block flag.
//               Outputs are zero when en_i is low.
// Ports       : state_i  - sponge state (rate in MSBs)
//               remain_i - bits still to be emitted
//               en_i     - formatter enable (engine is presenting a block)
//               data_o / bits_o / last_o - formatted block fields
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module squeeze_block_fmt
    import sponge_pkg::*;
#(
    parameter int unsigned RWIDTH      = 32,
    parameter int unsigned CWIDTH      = 320,
    parameter int unsigned REMAINWIDTH = 20,
    parameter int unsigned BITSW       = $clog2(RWIDTH) + 1
) (
    input  wire logic [RWIDTH+CWIDTH-1:0] state_i,
    input  wire logic [REMAINWIDTH-1:0]   remain_i,
    input  wire logic                     en_i,
    output logic [RWIDTH-1:0]             data_o,
    output logic [BITSW-1:0]              bits_o,
    output logic                          last_o
);

    logic [31:0]       w_remain32;
    int unsigned       w_len;
    logic [RWIDTH-1:0] w_mask;

    assign w_remain32 = 32'(remain_i);
    assign w_len      = min_len(w_remain32, RWIDTH);
    assign w_mask     = RWIDTH'(rate_mask(w_len, RWIDTH));

    assign data_o = en_i ? (state_i[RWIDTH+CWIDTH-1 -: RWIDTH] & w_mask) : '0;
    assign bits_o = en_i ? BITSW'(w_len) : '0;
    assign last_o = en_i && (w_remain32 <= RWIDTH);

endmodule

`default_nettype wire

// File: rtl/sponge_squeeze_stream.sv
// ============================================================================
// Module      : sponge_squeeze_stream
// Description : Sponge squeeze engine. Latches a full sponge state and an
//               output length, streams masked RWIDTH-bit blocks and drives
//               the external permutation between blocks.
// Ports       : clk, reset (async, active high)
//               start, abort, state_in, out_len, rounds - control/config
//               busy, done, perm_count                  - status
//               bus (master) - output stream and permutation handshake
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sponge_squeeze_stream
    import sponge_pkg::*;
#(
    parameter int unsigned RWIDTH      = 32,
    parameter int unsigned CWIDTH      = 320,
    parameter int unsigned REMAINWIDTH = 20,
    parameter int unsigned ROUND_COUNT = 10
) (
    input  wire logic                     clk,
    input  wire logic                     reset,
    input  wire logic                     start,
    input  wire logic                     abort,
    input  wire logic [RWIDTH+CWIDTH-1:0] state_in,
    input  wire logic [REMAINWIDTH-1:0]   out_len,
    input  wire logic [ROUND_COUNT-1:0]   rounds,
    output logic                          busy,
    output logic                          done,
    output logic [REMAINWIDTH-1:0]        perm_count,
    sponge_squeeze_stream_if.master       bus
);

    localparam int unsigned SWIDTH = RWIDTH + CWIDTH;
    localparam int unsigned BITSW  = $clog2(RWIDTH) + 1;

    squeeze_state_t         state_q, state_d;
    logic [SWIDTH-1:0]      sponge_q, sponge_d;
    logic [REMAINWIDTH-1:0] remain_q, remain_d;
    logic [REMAINWIDTH-1:0] perm_count_q, perm_count_d;

    logic                   w_emit;
    logic [RWIDTH-1:0]      w_data;
    logic [BITSW-1:0]       w_bits;
    logic                   w_last;

    assign w_emit = (state_q == S_EMIT);

    squeeze_block_fmt #(
        .RWIDTH      (RWIDTH),
        .CWIDTH      (CWIDTH),
        .REMAINWIDTH (REMAINWIDTH),
        .BITSW       (BITSW)
    ) u_fmt (
        .state_i  (sponge_q),
        .remain_i (remain_q),
        .en_i     (w_emit),
        .data_o   (w_data),
        .bits_o   (w_bits),
        .last_o   (w_last)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            sponge_q     <= '0;
            remain_q     <= '0;
            perm_count_q <= '0;
        end else begin
            state_q      <= state_d;
            sponge_q     <= sponge_d;
            remain_q     <= remain_d;
            perm_count_q <= perm_count_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        sponge_d     = sponge_q;
        remain_d     = remain_q;
        perm_count_d = perm_count_q;

        case (state_q)
            S_IDLE: begin
                // start beats a simultaneous abort here; abort only cancels work.
                if (start) begin
                    sponge_d     = state_in;
                    remain_d     = out_len;
                    perm_count_d = '0;
                    state_d      = (out_len == '0) ? S_FINISH : S_EMIT;
                end
            end
            S_EMIT: begin
                // abort wins over a same-cycle accept: the block is not consumed.
                if (abort) begin
                    state_d = S_FINISH;
                end else if (bus.out_ready) begin
                    remain_d = remain_q - REMAINWIDTH'(w_bits);
                    state_d  = w_last ? S_FINISH : S_PERM_REQ;
                end
            end
            S_PERM_REQ: begin
                state_d = abort ? S_FINISH : S_PERM_WAIT;
            end
            S_PERM_WAIT: begin
                if (abort) begin
                    state_d = S_FINISH;
                end else if (bus.perm_done) begin
                    sponge_d     = bus.perm_state_i;
                    perm_count_d = perm_count_q + 1'b1;
                    state_d      = S_EMIT;
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // All outputs decode registered state only; no input reaches an output
    // combinationally except the rounds field forwarded to the permutation.
    assign busy             = (state_q != S_IDLE);
    assign done             = (state_q == S_FINISH);
    assign perm_count       = perm_count_q;
    assign bus.out_valid    = w_emit;
    assign bus.out_data     = w_data;
    assign bus.out_bits     = w_bits;
    assign bus.out_last     = w_last;
    assign bus.perm_start   = (state_q == S_PERM_REQ);
    assign bus.perm_state_o = sponge_q;
    assign bus.perm_rounds  = rounds;

endmodule

`default_nettype wire

// File: tb/tb_sponge_squeeze_stream.sv
// ============================================================================
// Module      : tb_sponge_squeeze_stream
// Description : Scoreboard bench for the squeeze engine. The driver pushes
//               the expected block sequence for every squeeze; a monitor
//               compares every presented block against the queue head and
//               pops on handshake; a responder plays the permutation with a
//               known reference function.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sponge_squeeze_stream;

    localparam int unsigned RW  = 32;
    localparam int unsigned CW  = 320;
    localparam int unsigned REM = 20;
    localparam int unsigned RC  = 10;
    localparam int unsigned SW  = RW + CW;

    typedef struct packed {
        logic [RW-1:0] data;
        logic [5:0]    bits;
        logic          last;
    } blk_t;

    logic           clk;
    logic           reset;
    logic           start;
    logic           abort;
    logic [SW-1:0]  state_in;
    logic [REM-1:0] out_len;
    logic [RC-1:0]  rounds;
    logic           busy;
    logic           done;
    logic [REM-1:0] perm_count;

    sponge_squeeze_stream_if #(.RWIDTH(RW), .CWIDTH(CW), .ROUND_COUNT(RC)) bus ();

    sponge_squeeze_stream #(
        .RWIDTH(RW), .CWIDTH(CW), .REMAINWIDTH(REM), .ROUND_COUNT(RC)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .abort      (abort),
        .state_in   (state_in),
        .out_len    (out_len),
        .rounds     (rounds),
        .busy       (busy),
        .done       (done),
        .perm_count (perm_count),
        .bus        (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         n_vec = 0;
    int         n_err = 0;
    blk_t       exp_q[$];
    int         done_cnt   = 0;
    int         accepts_run = 0;
    int         perms_run  = 0;
    int         perm_lat   = 1;
    logic       perm_busy  = 1'b0;
    logic [SW-1:0] cap_state = '0;

    task automatic chk(input string name, input logic [SW-1:0] act, input logic [SW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference permutation: rotate left by 7, then XOR a fixed pattern.
    function automatic logic [SW-1:0] g_ref(input logic [SW-1:0] x);
        return {x[SW-8:0], x[SW-1:SW-7]} ^ {11{32'h9E37_79B9}};
    endfunction

    // ---------------------------------------------------------------- monitor
    initial begin
        logic prev_ps;
        blk_t e;
        prev_ps = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (bus.out_valid) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_valid", 1, 0);
                    end else begin
                        e = exp_q[0];
                        chk("out_data", bus.out_data, e.data);
                        chk("out_bits", bus.out_bits, e.bits);
                        chk("out_last", bus.out_last, e.last);
                        if (bus.out_ready && !abort) begin
                            void'(exp_q.pop_front());
                            accepts_run++;
                        end
                    end
                end
                if (bus.perm_start) begin
                    chk("perm_before_accept", (perms_run < accepts_run), 1);
                    chk("perm_pulse_width", prev_ps, 0);
                    chk("perm_rounds", bus.perm_rounds, rounds);
                    perms_run++;
                end
                prev_ps = bus.perm_start;
                if (done) done_cnt++;
            end else begin
                prev_ps = 1'b0;
            end
        end
    end

    // -------------------------------------------------------------- responder
    initial begin
        bus.perm_done    = 1'b0;
        bus.perm_state_i = '0;
        forever begin
            @(negedge clk);
            if (!reset && bus.perm_start) begin
                perm_busy = 1'b1;
                cap_state = bus.perm_state_o;
                repeat (perm_lat) begin
                    @(negedge clk);
                    chk("perm_state_stable", bus.perm_state_o, cap_state);
                end
                @(posedge clk); #1;
                bus.perm_done    = 1'b1;
                bus.perm_state_i = g_ref(cap_state);
                @(posedge clk); #1;
                bus.perm_done    = 1'b0;
                bus.perm_state_i = '0;
                perm_busy = 1'b0;
            end
        end
    end

    // ----------------------------------------------------------------- driver
    // Build a random state, push the reference block sequence, issue start.
    task automatic launch(input int len);
        logic [SW-1:0] st, s;
        logic [RW-1:0] mask;
        int rem, b;
        blk_t e;
        for (int i = 0; i < 11; i++) st[i*32 +: 32] = $urandom();
        s   = st;
        rem = len;
        while (rem > 0) begin
            b    = (rem < 32) ? rem : 32;
            mask = (b >= 32) ? 32'hFFFF_FFFF : ~(32'hFFFF_FFFF >> b);
            e.data = s[SW-1 -: RW] & mask;
            e.bits = 6'(b);
            e.last = (rem <= 32);
            exp_q.push_back(e);
            rem -= b;
            s = g_ref(s);
        end
        accepts_run = 0;
        perms_run   = 0;
        start    = 1'b1;
        state_in = st;
        out_len  = REM'(len);
        rounds   = RC'($urandom());
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_perm_idle();
        int w = 0;
        while (perm_busy && w < 50) begin
            @(posedge clk); #1;
            w++;
        end
        if (perm_busy) chk("perm_idle_timeout", 1, 0);
    endtask

    // abort_mode: 0 none, 1 abort in PERM_WAIT, 2 abort with accept in first EMIT
    task automatic squeeze(input int len, input int ready_pct, input int hold_first,
                           input int lat, input int abort_mode, input bit busy_start);
        int d0, cyc, nblk;
        bit aborted;
        nblk     = (len + 31) / 32;
        perm_lat = lat;
        d0       = done_cnt;
        aborted  = 1'b0;
        cyc      = 0;
        launch(len);
        while (done_cnt == d0 && cyc < 20000) begin
            abort = 1'b0;
            if (abort_mode == 2) begin
                bus.out_ready = 1'b1;
                abort = (cyc == 0);
            end else if (abort_mode == 1) begin
                bus.out_ready = 1'b1;
                if (perms_run >= 1 && !aborted) begin
                    abort   = 1'b1;
                    aborted = 1'b1;
                end
            end else begin
                bus.out_ready = (cyc < hold_first) ? 1'b0 : ($urandom_range(99) < ready_pct);
            end
            if (busy_start) begin
                start = (cyc == 3);
                if (cyc == 3) begin
                    for (int i = 0; i < 11; i++) state_in[i*32 +: 32] = $urandom();
                    out_len = REM'($urandom_range(1, 50));
                end
            end
            @(posedge clk); #1;
            cyc++;
        end
        abort = 1'b0;
        start = 1'b0;
        bus.out_ready = 1'b0;
        chk("done_pulse_count", done_cnt - d0, 1);
        @(posedge clk); #1;
        chk("done_single", done_cnt - d0, 1);
        chk("busy_after_done", busy, 0);
        if (len == 0) chk("len0_latency", (cyc <= 2), 1);
        case (abort_mode)
            0: begin
                chk("queue_drained", exp_q.size(), 0);
                chk("perm_pulses", perms_run, (nblk > 0) ? nblk - 1 : 0);
                chk("perm_count", perm_count, (nblk > 0) ? nblk - 1 : 0);
            end
            1: begin
                chk("abort_perm_count", perm_count, 0);
                chk("abort_perm_pulses", perms_run, 1);
                wait_perm_idle();
                repeat (3) @(posedge clk);
                #1;
                chk("abort_state_kept", bus.perm_state_o, cap_state);
                chk("abort_idle", busy, 0);
            end
            default: begin
                chk("abort_emit_accepts", accepts_run, 0);
                chk("abort_emit_perms", perms_run, 0);
                chk("abort_emit_count", perm_count, 0);
            end
        endcase
        exp_q.delete();
        wait_perm_idle();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"},      busy, 0);
        chk({tag, "_done"},      done, 0);
        chk({tag, "_valid"},     bus.out_valid, 0);
        chk({tag, "_data"},      bus.out_data, 0);
        chk({tag, "_bits"},      bus.out_bits, 0);
        chk({tag, "_last"},      bus.out_last, 0);
        chk({tag, "_pstart"},    bus.perm_start, 0);
        chk({tag, "_pstate"},    bus.perm_state_o, 0);
        chk({tag, "_pcount"},    perm_count, 0);
    endtask

    initial begin
        int d0;
        reset = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        state_in = '0;
        out_len  = '0;
        rounds   = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        reset = 1'b0;
        @(posedge clk); #1;

        // abort in IDLE is ignored
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("idle_abort_busy", busy, 0);

        squeeze(0,   100, 0, 1, 0, 1'b0);   // empty request
        squeeze(32,  100, 0, 1, 0, 1'b0);   // single full block
        squeeze(70,  100, 0, 2, 0, 1'b0);   // 32,32,6
        squeeze(70,  100, 5, 3, 0, 1'b0);   // consumer stalls on first block
        squeeze(100, 100, 0, 6, 1, 1'b0);   // abort while permutation pending
        squeeze(64,  100, 0, 1, 2, 1'b0);   // abort collides with accept
        squeeze(300, 100, 5, 1, 0, 1'b1);   // start while busy is ignored
        squeeze(1000, 100, 0, 1, 0, 1'b0);  // long stream

        for (int k = 0; k < 25; k++) begin
            squeeze($urandom_range(1, 200), $urandom_range(40, 100), $urandom_range(0, 3),
                    $urandom_range(1, 4), 0, 1'b0);
        end

        // Reset in the middle of EMIT: outputs clear without a clock edge.
        bus.out_ready = 1'b0;
        launch(64);
        @(posedge clk); #1;
        chk("pre_reset_valid", bus.out_valid, 1);
        #2;
        reset = 1'b1;
        #1;
        chk_all_zero("midreset");
        exp_q.delete();
        d0 = done_cnt;
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("midreset_no_done", done_cnt - d0, 0);
        chk("midreset_idle", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
